// File: rtl/instr_realign_pkg.sv
// Shared types and helpers for the instruction realigner.
package instr_realign_pkg;

    typedef enum logic [1:0] {
        S_ALIGN = 2'd0,
        S_HALF  = 2'd1,
        S_SKIP  = 2'd2
    } state_e;

    localparam logic [1:0] RVC_LO_MASK = 2'b11;

    function automatic logic is_rvc(input logic [15:0] hw);
        return (hw[1:0] & RVC_LO_MASK) != RVC_LO_MASK;
    endfunction

endpackage

// File: rtl/instr_word_fifo.sv
// Word FIFO holding {err, data} fetch entries; flush empties it synchronously.
module instr_word_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 33
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int unsigned   AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             push_en_s;
    logic             pop_en_s;

    assign full_o    = (count_q == FULL_CNT);
    assign empty_o   = (count_q == '0);
    assign push_en_s = push_i && !full_o && !flush_i;
    assign pop_en_s  = pop_i && !empty_o && !flush_i;
    assign head_o    = mem_q[rd_ptr_q];

    // Storage array write port
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (push_en_s) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of 2
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_en_s) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (pop_en_s) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            case ({push_en_s, pop_en_s})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/instr_realigner.sv
// Splits word-aligned fetch data into whole 16/32-bit instructions with their PCs.
// Compressed-instruction support is enabled by defining INSTR_REALIGN_RVC_EN.
module instr_realigner
    import instr_realign_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_valid_i,
    output logic        fetch_ready_o,
    input  logic [31:0] fetch_rdata_i,
    input  logic        fetch_err_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] out_instr_o,
    output logic [31:0] out_pc_o,
    output logic        out_err_o
);
    logic [32:0] head_s;
    logic        full_s;
    logic        empty_s;
    logic        pop_s;
    logic        valid_s;
    logic [31:0] instr_s;
    logic        err_s;
    logic [31:0] pc_q;
    logic [31:0] pc_d;

    instr_word_fifo #(.DEPTH(DEPTH), .WIDTH(33)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (fetch_valid_i && !full_s && !redirect_i),
        .pop_i   (pop_s),
        .flush_i (redirect_i),
        .wdata_i ({fetch_err_i, fetch_rdata_i}),
        .head_o  (head_s),
        .full_o  (full_s),
        .empty_o (empty_s)
    );

    assign fetch_ready_o = !full_s;
    assign out_valid_o   = valid_s;
    assign out_instr_o   = instr_s;
    assign out_err_o     = err_s;
    assign out_pc_o      = pc_q;

`ifdef INSTR_REALIGN_RVC_EN
    state_e      state_q, state_d;
    logic [15:0] stash_q, stash_d;
    logic        stash_err_q, stash_err_d;

    // Next-state, output selection and pop decision
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        stash_d     = stash_q;
        stash_err_d = stash_err_q;
        valid_s     = 1'b0;
        instr_s     = 32'h0000_0000;
        err_s       = 1'b0;
        pop_s       = 1'b0;
        case (state_q)
            S_ALIGN: begin
                if (!empty_s) begin
                    valid_s = 1'b1;
                    err_s   = head_s[32];
                    if (is_rvc(head_s[15:0])) begin
                        instr_s = {16'h0000, head_s[15:0]};
                        if (out_ready_i) begin
                            pop_s       = 1'b1;
                            stash_d     = head_s[31:16];
                            stash_err_d = head_s[32];
                            pc_d        = pc_q + 32'd2;
                            state_d     = S_HALF;
                        end else begin
                            pop_s = 1'b0;
                        end
                    end else begin
                        instr_s = head_s[31:0];
                        if (out_ready_i) begin
                            pop_s = 1'b1;
                            pc_d  = pc_q + 32'd4;
                        end else begin
                            pop_s = 1'b0;
                        end
                    end
                end else begin
                    valid_s = 1'b0;
                end
            end
            S_HALF: begin
                if (is_rvc(stash_q)) begin
                    // Stashed RVC needs no head word
                    valid_s = 1'b1;
                    instr_s = {16'h0000, stash_q};
                    err_s   = stash_err_q;
                    if (out_ready_i) begin
                        stash_d     = 16'h0000;
                        stash_err_d = 1'b0;
                        pc_d        = pc_q + 32'd2;
                        state_d     = S_ALIGN;
                    end else begin
                        stash_d = stash_q;
                    end
                end else if (!empty_s) begin
                    valid_s = 1'b1;
                    instr_s = {head_s[15:0], stash_q};
                    err_s   = stash_err_q | head_s[32];
                    if (out_ready_i) begin
                        pop_s       = 1'b1;
                        stash_d     = head_s[31:16];
                        stash_err_d = head_s[32];
                        pc_d        = pc_q + 32'd4;
                    end else begin
                        pop_s = 1'b0;
                    end
                end else begin
                    valid_s = 1'b0;
                end
            end
            S_SKIP: begin
                if (!empty_s) begin
                    pop_s       = 1'b1;
                    stash_d     = head_s[31:16];
                    stash_err_d = head_s[32];
                    state_d     = S_HALF;
                end else begin
                    pop_s = 1'b0;
                end
            end
            default: begin
                state_d = S_ALIGN;
            end
        endcase
        if (redirect_i) begin
            pop_s       = 1'b0;
            pc_d        = redirect_pc_i;
            stash_d     = 16'h0000;
            stash_err_d = 1'b0;
            state_d     = redirect_pc_i[1] ? S_SKIP : S_ALIGN;
        end else begin
            pc_d = pc_d;
        end
    end

    // Sequencer state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_ALIGN;
            pc_q        <= RESET_PC;
            stash_q     <= 16'h0000;
            stash_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            stash_q     <= stash_d;
            stash_err_q <= stash_err_d;
        end
    end
`else
    logic misalign_q, misalign_d;

    // Whole-word output; a misaligned redirect taints the next instruction
    always_comb begin
        pc_d       = pc_q;
        misalign_d = misalign_q;
        valid_s    = 1'b0;
        instr_s    = 32'h0000_0000;
        err_s      = 1'b0;
        pop_s      = 1'b0;
        if (redirect_i) begin
            pc_d       = {redirect_pc_i[31:2], 2'b00};
            misalign_d = redirect_pc_i[1] | redirect_pc_i[0];
        end else if (!empty_s) begin
            valid_s = 1'b1;
            instr_s = head_s[31:0];
            err_s   = head_s[32] | misalign_q;
            if (out_ready_i) begin
                pop_s      = 1'b1;
                pc_d       = pc_q + 32'd4;
                misalign_d = 1'b0;
            end else begin
                pop_s = 1'b0;
            end
        end else begin
            valid_s = 1'b0;
        end
    end

    // PC and pending-misalignment registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            misalign_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            misalign_q <= misalign_d;
        end
    end
`endif

endmodule

// File: tb/tb_instr_realigner.sv
// Self-checking bench for instr_realigner; expectations follow INSTR_REALIGN_RVC_EN.
module tb_instr_realigner;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_valid_i;
    logic        fetch_ready_o;
    logic [31:0] fetch_rdata_i;
    logic        fetch_err_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] out_instr_o;
    logic [31:0] out_pc_o;
    logic        out_err_o;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        err;
    } exp_t;

    typedef struct packed {
        logic [31:0]      rpc;
        logic [1:0]       nw;
        logic [1:0][31:0] w;
        logic [1:0]       e;
        logic [1:0]       no;
        logic [2:0][31:0] ei;
        logic [2:0][31:0] ep;
        logic [2:0]       ee;
        logic [31:0]      npc;
    } vec_t;

    exp_t exp_q[$];
    vec_t vecs[6];

    instr_realigner #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .clk           (clk),
        .rst           (rst),
        .fetch_valid_i (fetch_valid_i),
        .fetch_ready_o (fetch_ready_o),
        .fetch_rdata_i (fetch_rdata_i),
        .fetch_err_i   (fetch_err_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .out_valid_o   (out_valid_o),
        .out_ready_i   (out_ready_i),
        .out_instr_o   (out_instr_o),
        .out_pc_o      (out_pc_o),
        .out_err_o     (out_err_o)
    );

    always #5 clk = ~clk;

    function automatic vec_t mkv(
        input logic [31:0] rpc, input logic [1:0] nw,
        input logic [31:0] w0, input logic e0, input logic [31:0] w1, input logic e1,
        input logic [1:0] no,
        input logic [31:0] i0, input logic [31:0] p0, input logic r0,
        input logic [31:0] i1, input logic [31:0] p1, input logic r1,
        input logic [31:0] i2, input logic [31:0] p2, input logic r2,
        input logic [31:0] npc);
        vec_t v;
        v.rpc = rpc; v.nw = nw; v.w = {w1, w0}; v.e = {e1, e0};
        v.no = no; v.ei = {i2, i1, i0}; v.ep = {p2, p1, p0}; v.ee = {r2, r1, r0};
        v.npc = npc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Redirect while also offering a junk word that must be dropped
    task automatic do_redirect(input logic [31:0] pc);
        redirect_i    = 1'b1;
        redirect_pc_i = pc;
        fetch_valid_i = 1'b1;
        fetch_rdata_i = 32'hDEAD_BEEF;
        fetch_err_i   = 1'b0;
        @(posedge clk);
        #1;
        redirect_i    = 1'b0;
        fetch_valid_i = 1'b0;
    endtask

    task automatic push_word(input logic [31:0] w, input logic e);
        fetch_valid_i = 1'b1;
        fetch_rdata_i = w;
        fetch_err_i   = e;
        @(posedge clk);
        #1;
        fetch_valid_i = 1'b0;
        fetch_err_i   = 1'b0;
    endtask

    // Consume outputs against the scoreboard, then check idle state and next PC
    task automatic drain(input logic [31:0] npc, input string tag);
        int cyc;
        exp_t e;
        cyc = 0;
        out_ready_i = 1'b1;
        while (exp_q.size() > 0 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (out_valid_o) begin
                e = exp_q.pop_front();
                chk($sformatf("%s_instr", tag), out_instr_o, e.instr);
                chk($sformatf("%s_pc", tag), out_pc_o, e.pc);
                chk($sformatf("%s_err", tag), 32'(out_err_o), 32'(e.err));
            end
        end
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout: got %0d outputs missing, expected 0", tag, exp_q.size());
            exp_q.delete();
        end
        @(posedge clk);
        #1;
        out_ready_i = 1'b0;
        @(negedge clk);
        chk($sformatf("%s_idle", tag), 32'(out_valid_o), 32'd0);
        chk($sformatf("%s_npc", tag), out_pc_o, npc);
        @(posedge clk);
        #1;
    endtask

    initial begin
`ifdef INSTR_REALIGN_RVC_EN
        vecs[0] = mkv(32'h0, 2'd1, 32'h0001_0513, 1'b0, 32'h0, 1'b0, 2'd1,
                      32'h0001_0513, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h4);
        vecs[1] = mkv(32'h0, 2'd1, 32'h4501_4505, 1'b0, 32'h0, 1'b0, 2'd2,
                      32'h0000_4505, 32'h0, 1'b0, 32'h0000_4501, 32'h2, 1'b0, 32'h0, 32'h0, 1'b0, 32'h4);
        vecs[2] = mkv(32'h0, 2'd2, 32'h0513_4505, 1'b0, 32'h1234_0001, 1'b0, 2'd3,
                      32'h0000_4505, 32'h0, 1'b0, 32'h0001_0513, 32'h2, 1'b0, 32'h0000_1234, 32'h6, 1'b0, 32'h8);
        vecs[3] = mkv(32'h102, 2'd1, 32'h4581_FFFF, 1'b0, 32'h0, 1'b0, 2'd1,
                      32'h0000_4581, 32'h102, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h104);
        vecs[4] = mkv(32'h0, 2'd2, 32'h0513_4505, 1'b1, 32'h1234_0001, 1'b0, 2'd3,
                      32'h0000_4505, 32'h0, 1'b1, 32'h0001_0513, 32'h2, 1'b1, 32'h0000_1234, 32'h6, 1'b0, 32'h8);
        vecs[5] = mkv(32'hFFFF_FFFE, 2'd1, 32'h4505_0000, 1'b0, 32'h0, 1'b0, 2'd1,
                      32'h0000_4505, 32'hFFFF_FFFE, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
`else
        vecs[0] = mkv(32'h0, 2'd1, 32'h0001_0513, 1'b0, 32'h0, 1'b0, 2'd1,
                      32'h0001_0513, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h4);
        vecs[1] = mkv(32'h0, 2'd1, 32'h4501_4505, 1'b0, 32'h0, 1'b0, 2'd1,
                      32'h4501_4505, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h4);
        vecs[2] = mkv(32'h0, 2'd2, 32'h0513_4505, 1'b0, 32'h1234_0001, 1'b0, 2'd2,
                      32'h0513_4505, 32'h0, 1'b0, 32'h1234_0001, 32'h4, 1'b0, 32'h0, 32'h0, 1'b0, 32'h8);
        vecs[3] = mkv(32'h102, 2'd1, 32'h4581_FFFF, 1'b0, 32'h0, 1'b0, 2'd1,
                      32'h4581_FFFF, 32'h100, 1'b1, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h104);
        vecs[4] = mkv(32'h0, 2'd2, 32'h0513_4505, 1'b1, 32'h1234_0001, 1'b0, 2'd2,
                      32'h0513_4505, 32'h0, 1'b1, 32'h1234_0001, 32'h4, 1'b0, 32'h0, 32'h0, 1'b0, 32'h8);
        vecs[5] = mkv(32'hFFFF_FFFE, 2'd1, 32'h4505_0000, 1'b0, 32'h0, 1'b0, 2'd1,
                      32'h4505_0000, 32'hFFFF_FFFC, 1'b1, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
`endif

        rst           = 1'b1;
        fetch_valid_i = 1'b0;
        fetch_rdata_i = 32'h0;
        fetch_err_i   = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = 32'h0;
        out_ready_i   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_valid", 32'(out_valid_o), 32'd0);
        chk("rst_instr", out_instr_o, 32'h0);
        chk("rst_err", 32'(out_err_o), 32'd0);
        chk("rst_pc", out_pc_o, 32'h0);
        chk("rst_ready", 32'(fetch_ready_o), 32'd1);
        @(posedge clk);
        #1;

        // Table-driven single-burst vectors
        for (int v = 0; v < 6; v++) begin
            do_redirect(vecs[v].rpc);
            for (int k = 0; k < int'(vecs[v].nw); k++) begin
                push_word(vecs[v].w[k], vecs[v].e[k]);
            end
            for (int k = 0; k < int'(vecs[v].no); k++) begin
                exp_q.push_back('{instr: vecs[v].ei[k], pc: vecs[v].ep[k], err: vecs[v].ee[k]});
            end
            drain(vecs[v].npc, $sformatf("vec%0d", v));
        end

        // Full FIFO: fifth word waits for a pop, ready stays low in the popping cycle
        do_redirect(32'h0);
        for (int i = 0; i < 4; i++) begin
            push_word({12'(i), 20'h00013}, 1'b0);
        end
        fetch_valid_i = 1'b1;
        fetch_rdata_i = {12'd4, 20'h00013};
        chk("full_after4", 32'(fetch_ready_o), 32'd0);
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back('{instr: {12'(i), 20'h00013}, pc: 32'(i * 4), err: 1'b0});
        end
        out_ready_i = 1'b1;
        fork
            drain(32'd20, "full");
            begin
                bit done;
                done = 1'b0;
                for (int c = 0; c < 20 && !done; c++) begin
                    @(negedge clk);
                    if (fetch_ready_o) begin
                        @(posedge clk);
                        #1;
                        fetch_valid_i = 1'b0;
                        done = 1'b1;
                    end
                end
                fetch_valid_i = 1'b0;
                chk("full_refill", 32'(done), 32'd1);
            end
            begin
                @(negedge clk);
                chk("full_ready_pop", 32'(fetch_ready_o), 32'd0);
                chk("full_pop_active", 32'(out_valid_o & out_ready_i), 32'd1);
            end
        join

        // Redirect coinciding with an accepted output and a push
        do_redirect(32'h0);
        push_word(32'h0001_0513, 1'b0);
        push_word(32'h0002_0513, 1'b0);
        out_ready_i   = 1'b1;
        fetch_valid_i = 1'b1;
        fetch_rdata_i = 32'h0003_0513;
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h40;
        @(posedge clk);
        #1;
        out_ready_i   = 1'b0;
        fetch_valid_i = 1'b0;
        redirect_i    = 1'b0;
        @(negedge clk);
        chk("redir_valid", 32'(out_valid_o), 32'd0);
        chk("redir_pc", out_pc_o, 32'h40);
        repeat (2) @(negedge clk);
        chk("redir_empty", 32'(out_valid_o), 32'd0);
        push_word(32'h0004_0513, 1'b0);
        exp_q.push_back('{instr: 32'h0004_0513, pc: 32'h40, err: 1'b0});
        drain(32'h44, "redir");

        // Asynchronous reset in the middle of a cycle
        do_redirect(32'h80);
        push_word(32'h0005_0513, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", 32'(out_valid_o), 32'd0);
        chk("arst_pc", out_pc_o, 32'h0);
        chk("arst_instr", out_instr_o, 32'h0);
        #2;
        rst = 1'b0;
        @(negedge clk);
        chk("arst_flushed", 32'(out_valid_o), 32'd0);
        chk("arst_ready", 32'(fetch_ready_o), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
